// File: rtl/app_pkg.sv
// Shared definitions for the PPM link application layer: frame constants,
// status codes, responder state encoding and the CRC8 used on data frames.
package app_pkg;

    localparam logic [47:0] FRAME_READY = 48'h1f_1f1f_1f1f_99;
    localparam logic [47:0] FRAME_ACK   = 48'h2d_2d2d_2d2d_66;
    localparam logic [47:0] FRAME_NAK   = 48'ha5_a5a5_a5a5_12;
    localparam logic [7:0]  HDR_DATA    = 8'h3c;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_BAD     = 2'b10,
        ERR_BUSY    = 2'b11
    } err_code_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SEND     = 3'd1;
    localparam state_t ST_TX_WAIT  = 3'd2;
    localparam state_t ST_WAIT_PKT = 3'd3;
    localparam state_t ST_CHECK    = 3'd4;
    localparam state_t ST_FAIL     = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

    // CRC8, polynomial 0x07, init 0, no reflection, no final XOR, MSB first.
    function automatic logic [7:0] crc8(input logic [31:0] data);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            if (crc[7] ^ data[i]) begin
                crc = {crc[6:0], 1'b0} ^ 8'h07;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/app_timeout_ctr.sv
// 32-bit wait timer: cleared on request, counts while enabled and parks at
// LIMIT, raising done for as long as it sits there.
module app_timeout_ctr #(
    parameter logic [31:0] LIMIT = 32'hffff
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: clear wins, otherwise count up until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LIMIT);

endmodule

// File: rtl/app_rx_responder.sv
// Receive-side application responder: announces READY, pops one data frame
// from the Decoder, validates header/CRC and answers ACK or NAK through the
// Encoder, retrying on bad frames or timeouts up to ERRORS_ALLOWED attempts.
module app_rx_responder
    import app_pkg::*;
#(
    parameter int unsigned N_PKT          = 48,
    parameter logic [31:0] TIMEOUT_TICKS  = 32'hffff,
    parameter int unsigned ERRORS_ALLOWED = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             avail,
    output logic [1:0]       err_code,
    output logic [N_PKT-1:0] data_recv,
    output logic             start_ENC,
    output logic [N_PKT-1:0] data_ENC,
    input  logic             avail_ENC,
    input  logic [N_PKT-1:0] data_DEC,
    input  logic             avail_DEC,
    input  logic             error_DEC,
    output logic             read_DEC
);

    localparam logic [3:0] ERR_LIMIT = 4'(ERRORS_ALLOWED);

    state_t           state_q, state_d;
    logic [N_PKT-1:0] frame_q, frame_d;
    err_code_t        cause_q, cause_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    err_code_t        err_code_q, err_code_d;
    logic [N_PKT-1:0] data_recv_q, data_recv_d;
    logic [N_PKT-1:0] data_enc_q, data_enc_d;
    logic             start_enc_q, start_enc_d;
    logic             read_dec_q, read_dec_d;
    logic [N_PKT-1:0] dec_data_q, dec_data_d;
    logic             dec_err_q, dec_err_d;
    logic             seen_low_q, seen_low_d;

    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_done;
    logic [7:0]       rx_hdr;
    logic [31:0]      rx_payload;
    logic [7:0]       rx_crc;
    logic             rx_good;

    app_timeout_ctr #(
        .LIMIT (TIMEOUT_TICKS)
    ) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (tmr_done)
    );

    assign rx_hdr     = dec_data_q[N_PKT-1 -: 8];
    assign rx_payload = dec_data_q[N_PKT-9 -: 32];
    assign rx_crc     = dec_data_q[7:0];
    // A frame flagged corrupt by the Decoder is rejected even if it looks valid.
    assign rx_good    = !dec_err_q && (rx_hdr == HDR_DATA) && (rx_crc == crc8(rx_payload));

    // Transaction sequencer: next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        cause_d     = cause_q;
        err_cnt_d   = err_cnt_q;
        err_code_d  = err_code_q;
        data_recv_d = data_recv_q;
        data_enc_d  = data_enc_q;
        start_enc_d = 1'b0;
        read_dec_d  = 1'b0;
        dec_data_d  = dec_data_q;
        dec_err_d   = dec_err_q;
        seen_low_d  = seen_low_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    frame_d    = FRAME_READY;
                    err_code_d = ERR_BUSY;
                    err_cnt_d  = '0;
                end
            end
            ST_SEND: begin
                if (avail_ENC) begin
                    start_enc_d = 1'b1;
                    data_enc_d  = frame_q;
                    seen_low_d  = 1'b0;
                    state_d     = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                // The Encoder must be seen busy before its idle counts as done.
                if (!avail_ENC) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    if (frame_q == FRAME_ACK) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_PKT;
                        tmr_clr = 1'b1;
                    end
                end
            end
            ST_WAIT_PKT: begin
                tmr_en = 1'b1;
                // A frame on the timeout cycle is still taken.
                if (avail_DEC) begin
                    read_dec_d = 1'b1;
                    dec_data_d = data_DEC;
                    dec_err_d  = error_DEC;
                    state_d    = ST_CHECK;
                end else if (tmr_done) begin
                    cause_d = ERR_TIMEOUT;
                    frame_d = FRAME_READY;
                    state_d = ST_FAIL;
                end
            end
            ST_CHECK: begin
                if (rx_good) begin
                    data_recv_d = dec_data_q;
                    frame_d     = FRAME_ACK;
                    state_d     = ST_SEND;
                end else begin
                    cause_d = ERR_BAD;
                    frame_d = FRAME_NAK;
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                err_cnt_d = err_cnt_q + 4'd1;
                if ((err_cnt_q + 4'd1) == ERR_LIMIT) begin
                    err_code_d = cause_q;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                err_code_d = ERR_OK;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            cause_q     <= ERR_BUSY;
            err_cnt_q   <= '0;
            err_code_q  <= ERR_BUSY;
            data_recv_q <= '0;
            data_enc_q  <= '0;
            start_enc_q <= 1'b0;
            read_dec_q  <= 1'b0;
            dec_data_q  <= '0;
            dec_err_q   <= 1'b0;
            seen_low_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cause_q     <= cause_d;
            err_cnt_q   <= err_cnt_d;
            err_code_q  <= err_code_d;
            data_recv_q <= data_recv_d;
            data_enc_q  <= data_enc_d;
            start_enc_q <= start_enc_d;
            read_dec_q  <= read_dec_d;
            dec_data_q  <= dec_data_d;
            dec_err_q   <= dec_err_d;
            seen_low_q  <= seen_low_d;
        end
    end

    assign avail     = (state_q == ST_IDLE);
    assign err_code  = err_code_q;
    assign data_recv = data_recv_q;
    assign start_ENC = start_enc_q;
    assign data_ENC  = data_enc_q;
    assign read_DEC  = read_dec_q;

endmodule

// File: doc/app_rx_responder.md
# app_rx_responder

Application-layer responder for the receiving end of the PPM link. It sits between the host and the local Encoder/Decoder pair. It announces readiness with a READY frame, accepts one 48-bit data frame from the Decoder, and validates the header and CRC8. It replies ACK or NAK through the Encoder, with bounded retries and a timeout.

## Interface
Parameters:
- N_PKT, 48: frame width in bits.
- TIMEOUT_TICKS, 32'hffff: number of cycles to wait for a data frame.
- ERRORS_ALLOWED, 8: number of failed attempts before the block aborts.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  pulse; begins one receive transaction (accepted only in IDLE).
- avail  out  1  high in IDLE; the block can accept start.
- err_code  out  2  transaction status: 00 success, 01 aborted on timeout, 10 aborted on bad frames, 11 busy or no result.
- data_recv  out  N_PKT  last good frame (header, payload, crc); holds until the next good frame.
- start_ENC  out  1  one-cycle request to the Encoder.
- data_ENC  out  N_PKT  frame to transmit; held stable while the Encoder is busy.
- avail_ENC  in  1  Encoder idle.
- data_DEC  in  N_PKT  decoded frame.
- avail_DEC  in  1  Decoder has a frame.
- error_DEC  in  1  decoded frame is corrupt (valid while avail_DEC is high).
- read_DEC  out  1  one-cycle pop of the Decoder frame.

## Operation
- Frame constants:
  - READY = 48'h1f_1f1f_1f1f_99
  - ACK = 48'h2d_2d2d_2d2d_66
  - NAK = 48'ha5_a5a5_a5a5_12
  - Data header = 8'h3c
  - Data layout = {hdr[47:40], payload[39:8], crc[7:0]}
- CRC8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Computed over the 32-bit payload, MSB first.
- States:
  - IDLE: start → SEND (frame = READY), err_code := 11, err_cnt := 0.
  - SEND: wait for avail_ENC = 1, then pulse start_ENC with data_ENC = frame → TX_WAIT.
  - TX_WAIT: wait for avail_ENC to fall and then rise again.
    - If frame was ACK → DONE.
    - Otherwise → WAIT_PKT with the timer cleared.
  - WAIT_PKT: timer increments each cycle.
    - avail_DEC = 1 → pulse read_DEC, latch data_DEC and error_DEC → CHECK.
    - Timer reaches TIMEOUT_TICKS → FAIL (cause = timeout, frame = READY).
  - CHECK:
    - Good frame (error_DEC = 0, header = 3c, crc matches) → data_recv := frame, SEND (frame = ACK).
    - Bad frame → FAIL (cause = bad, frame = NAK).
  - FAIL: err_cnt++.
    - err_cnt + 1 = ERRORS_ALLOWED → err_code := 01 for timeout or 10 for bad → IDLE.
    - Otherwise → SEND.
  - DONE: err_code := 00 → IDLE.
- err_code holds its value until the next start.
- The block ignores start outside IDLE.
- The block ignores avail_DEC outside WAIT_PKT; no read_DEC is issued then, so stale frames stay in the Decoder.

## Timing
- Reset values:
  - State IDLE, avail 1, err_code 11, data_recv 0, start_ENC 0, data_ENC 0, read_DEC 0.
  - err_cnt and the timer are 0.
- Reset asserted mid-transaction returns every output to its reset value on the next edge. No partial response is emitted after that.
- start is sampled on the clock edge. avail falls the following cycle.
- read_DEC rises the cycle after avail_DEC is sampled high in WAIT_PKT. It is exactly one cycle wide.
- CHECK takes 1 cycle (combinational CRC).
- start_ENC is exactly one cycle wide. data_ENC is registered and does not change until TX_WAIT completes.
- Timer: the 32-bit counter saturates at TIMEOUT_TICKS.
  - A frame arriving on the same cycle as the timeout takes priority over the timeout.
- err_cnt is 4 bits wide; ERRORS_ALLOWED must be ≤ 15.
- Cycles from a good frame's avail_DEC to err_code = 00: 3 cycles, plus the Encoder's ACK duration.

## Structure
- Package app_pkg holds:
  - the READY/ACK/NAK/HDR constants
  - the err_code enum (ERR_OK, ERR_TIMEOUT, ERR_BAD, ERR_BUSY)
  - the state typedef
  - function crc8(logic [31:0]), shared with the transmitter and the benches.
- Sub-module app_timeout_ctr: 32-bit counter with clear, enable and a terminal flag.

## Test plan
- Test-only parameters: TIMEOUT_TICKS 2000, ERRORS_ALLOWED 3.
- Happy path: start; after READY is sent, the Decoder returns 48'h3c_00000001_07 → ACK is sent, data_recv = 48'h3c00000001_07, err_code = 00, avail = 1.
- Bad CRC: frame 48'h3c_00000001_00, then a good frame → NAK then ACK, err_code = 00.
- Bad header: frame 48'h5a_00000000_00 sent 3 times → 3 NAKs are not all sent; the 3rd failure aborts with err_code = 10, avail = 1.
- Timeout: no frame for 3 × TIMEOUT_TICKS (2000) cycles → READY sent 3 times in total, err_code = 01.
- error_DEC high with a valid-looking frame → treated as bad, NAK sent, err_cnt = 1.
- Reset mid-WAIT_PKT, and a spurious avail_DEC pulse while in IDLE → outputs at reset values, no read_DEC pulse.
